// File: rtl/div32_iter.sv
// Iterative radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle; start/busy/valid handshake lets the pipeline stall on it.
module div32_iter #(
    parameter int W  = 32,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic         busy,
    output logic         valid,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         dz
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_DZ, SP_OVF} special_t;

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    state_t        state;
    special_t      special;
    logic [CW-1:0] cnt;
    logic [W-1:0]  prem;     // partial remainder
    logic [W-1:0]  dvd;      // dividend shifting out, quotient shifting in
    logic [W-1:0]  dvs;
    logic [W-1:0]  a_cap;
    logic          sign_q;
    logic          sign_r;

    logic [W-1:0]  abs_a;
    logic [W-1:0]  abs_b;
    logic [W:0]    trial;
    logic          ge;

    assign abs_a = (mode && a[W-1]) ? (~a + W'(1)) : a;
    assign abs_b = (mode && b[W-1]) ? (~b + W'(1)) : b;

    // prem < dvs holds throughout, so a W+1-bit difference cannot wrap and its MSB is the borrow.
    assign trial = {prem, dvd[W-1]} - {1'b0, dvs};
    assign ge    = ~trial[W];

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, including the datapath, is reset so no X ever reaches quo/rem.
            state   <= S_IDLE;
            special <= SP_NONE;
            cnt     <= '0;
            prem    <= '0;
            dvd     <= '0;
            dvs     <= '0;
            a_cap   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            quo     <= '0;
            rem     <= '0;
            dz      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_cap  <= a;
                        dvd    <= abs_a;
                        dvs    <= abs_b;
                        prem   <= '0;
                        cnt    <= CW'(W);
                        sign_q <= mode & (a[W-1] ^ b[W-1]);
                        sign_r <= mode & a[W-1];
                        busy   <= 1'b1;
                        if (b == '0) begin
                            special <= SP_DZ;
                            state   <= S_FIX;
                        end else if (mode && a == MIN_NEG && (&b)) begin
                            special <= SP_OVF;
                            state   <= S_FIX;
                        end else begin
                            special <= SP_NONE;
                            state   <= S_DIV;
                        end
                    end
                end

                S_DIV: begin
                    prem <= ge ? trial[W-1:0] : {prem[W-2:0], dvd[W-1]};
                    dvd  <= {dvd[W-2:0], ge};
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= S_FIX;
                    end
                end

                S_FIX: begin
                    case (special)
                        SP_DZ: begin
                            quo <= '1;
                            rem <= a_cap;
                            dz  <= 1'b1;
                        end
                        SP_OVF: begin
                            quo <= a_cap;
                            rem <= '0;
                            dz  <= 1'b0;
                        end
                        default: begin
                            quo <= sign_q ? (~dvd + W'(1)) : dvd;
                            rem <= sign_r ? (~prem + W'(1)) : prem;
                            dz  <= 1'b0;
                        end
                    endcase
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32_iter.sv
// Directed self-checking bench for div32_iter: arithmetic, latency, handshake and async reset.
module tb_div32_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic        busy;
    logic        valid;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dz;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;
    int lat   = 0;
    logic seen;

    div32_iter #(.W(32), .CW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .mode  (mode),
        .busy  (busy),
        .valid (valid),
        .quo   (quo),
        .rem   (rem),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; the start edge E0 is recorded in t0 and operands are scrambled afterwards.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic mv);
        start = 1'b1;
        a     = av;
        b     = bv;
        mode  = mv;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
        mode  = ~mv;
    endtask

    // Returns at the negedge of the valid cycle; lat = edges since E0, or -1 on timeout.
    task automatic wait_valid();
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] av, input logic [31:0] bv,
                             input logic mv, input int exp_lat, input logic [31:0] exp_q,
                             input logic [31:0] exp_r, input logic exp_dz);
        start_op(av, bv, mv);
        wait_valid();
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".quo"}, quo, exp_q);
        check({tag, ".rem"}, rem, exp_r);
        check({tag, ".dz"}, {31'b0, dz}, {31'b0, exp_dz});
        check({tag, ".busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        mode  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.valid", {31'b0, valid}, 32'd0);
        check("rst.quo", quo, 32'd0);
        check("rst.rem", rem, 32'd0);
        check("rst.dz", {31'b0, dz}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic unsigned; check the one-cycle valid pulse and that results hold.
        run_check("udiv", 32'd6785, 32'd292, 1'b0, 33, 32'd23, 32'd69, 1'b0);
        @(negedge clk);
        check("udiv.pulse", {31'b0, valid}, 32'd0);
        check("udiv.hold", quo, 32'd23);

        run_check("sdiv_n7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        run_check("sdiv_7_n2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
        @(negedge clk);

        run_check("dz_s", 32'h8FA4_B672, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'h8FA4_B672, 1'b1);
        @(negedge clk);
        run_check("dz_u", 32'h8FA4_B672, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'h8FA4_B672, 1'b1);
        @(negedge clk);

        run_check("ovf_s", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'h8000_0000, 32'd0, 1'b0);
        @(negedge clk);
        run_check("ovf_u", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 32'd0, 32'h8000_0000, 1'b0);
        @(negedge clk);

        // Start pulse mid-DIV must be ignored.
        start_op(32'hFFFF_FFFF, 32'h10, 1'b0);
        repeat (5) @(negedge clk);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd3;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid();
        check("ign.lat", lat, 33);
        check("ign.quo", quo, 32'h0FFF_FFFF);
        check("ign.rem", rem, 32'hF);

        // Back-to-back: start issued in the valid cycle.
        run_check("b2b", 32'hFFFF_FF9C, 32'd7, 1'b1, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_check("b2b2", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);

        // Async reset at cycle 10 of an operation.
        @(negedge clk);
        start_op(32'd5000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        check("abort.busy_pre", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.busy", {31'b0, busy}, 32'd0);
        check("abort.valid", {31'b0, valid}, 32'd0);
        check("abort.quo", quo, 32'd0);
        check("abort.rem", rem, 32'd0);
        check("abort.dz", {31'b0, dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("abort.no_valid", {31'b0, seen}, 32'd0);

        run_check("post", 32'd1000, 32'd33, 1'b0, 33, 32'd30, 32'd10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
